// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Memory-side stage sitting directly after the CPU control unit. It owns the
// MAR and MDR, converts the control unit's read/write strobes into a
// multi-cycle handshake with a word-addressed synchronous RAM, returns the MDR
// onto the internal bus and reports completion with a one-cycle mem_done.
//
// Build option:
//   MEM_BOUNDS_CHECK_EN - when defined, an access whose MAR is >= MEM_WORDS
//                         is not issued to the RAM; mem_err is raised and a
//                         read returns 32'hDEAD_BEEF at the normal latency.
//                         When undefined, the address wraps to ADDR_W bits.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   bus_in     in   internal CPU bus (MAR/MDR load source)
//   mar_in     in   load MAR from bus_in (IDLE/DONE only)
//   mdr_in     in   load MDR from bus_in (IDLE/DONE only)
//   mdr_out    in   drive MDR onto bus_out
//   read       in   start a RAM read (edge-qualified level)
//   write      in   start a RAM write (edge-qualified level, wins over read)
//   bus_out    out  MDR when mdr_out=1, else 0
//   mar_q      out  MAR contents
//   mem_busy   out  access in progress
//   mem_done   out  one-cycle completion pulse
//   mem_err    out  sticky protocol-error flag (cleared by reset only)
//   ram_addr   out  RAM word address, frozen for the whole access
//   ram_wdata  out  RAM write data (= MDR)
//   ram_re     out  RAM read enable
//   ram_we     out  RAM write enable (single-cycle pulse)
//   ram_rdata  in   RAM read data
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int MEM_WORDS = 512,
    parameter int RD_LAT    = 2,
    parameter int WR_WAIT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              mdr_out,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] bus_out,
    output logic [DATA_W-1:0] mar_q,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_WAIT  = 3'd1,
        S_WR_WAIT  = 3'd2,
        S_WR_PULSE = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // Read: the wait state lasts RD_LAT cycles, so the counter starts at RD_LAT-1.
    localparam logic [3:0] RD_CNT_INIT = 4'(RD_LAT - 1);
    // Write: WR_WAIT idle cycles precede the pulse; a zero setting still
    // spends one cycle in the wait state, hence the clamp.
    localparam logic [3:0] WR_CNT_INIT = (WR_WAIT == 0) ? 4'd0 : 4'(WR_WAIT - 1);
    localparam logic [DATA_W-1:0] OOB_PATTERN = DATA_W'(32'hDEAD_BEEF);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mdr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_re;
    logic              r_we;
    logic              r_oob;
    logic              r_rd_arm;
    logic              r_wr_arm;

    logic              w_accept;
    logic              w_rd_go;
    logic              w_wr_go;
    logic              w_start;
    logic              w_oob;
    logic              w_err_set;

    // New accesses (and MAR/MDR loads) are only accepted in IDLE or DONE;
    // accepting in DONE gives back-to-back accesses without a bubble.
    assign w_accept = (r_state == S_IDLE) || (r_state == S_DONE);

    // A strobe only starts an access once it has been seen low since the
    // last access it started, so a level held through DONE cannot retrigger.
    assign w_rd_go = read  & r_rd_arm;
    assign w_wr_go = write & r_wr_arm;
    assign w_start = w_accept & (w_rd_go | w_wr_go);

`ifdef MEM_BOUNDS_CHECK_EN
    assign w_oob = (r_mar >= DATA_W'(MEM_WORDS));
`else
    assign w_oob = 1'b0;
`endif

    assign w_err_set = (~w_accept & (mar_in | mdr_in))
                     | (w_accept & w_wr_go & read)
                     | (w_start & w_oob);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_mar    <= '0;
            r_mdr    <= '0;
            r_addr   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_re     <= 1'b0;
            r_we     <= 1'b0;
            r_oob    <= 1'b0;
            r_rd_arm <= 1'b1;
            r_wr_arm <= 1'b1;
        end else begin
            r_done <= 1'b0;
            r_we   <= 1'b0;

            if (!read)
                r_rd_arm <= 1'b1;
            else if (w_start)
                r_rd_arm <= 1'b0;

            if (!write)
                r_wr_arm <= 1'b1;
            else if (w_start)
                r_wr_arm <= 1'b0;

            if (w_err_set)
                r_err <= 1'b1;

            if (w_accept && mar_in)
                r_mar <= bus_in;
            if (w_accept && mdr_in)
                r_mdr <= bus_in;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_wr_go) begin
                        r_state <= S_WR_WAIT;
                        r_cnt   <= WR_CNT_INIT;
                        r_busy  <= 1'b1;
                        r_re    <= 1'b0;
                        r_addr  <= r_mar[ADDR_W-1:0];
                        r_oob   <= w_oob;
                    end else if (w_rd_go) begin
                        r_state <= S_RD_WAIT;
                        r_cnt   <= RD_CNT_INIT;
                        r_busy  <= 1'b1;
                        r_re    <= ~w_oob;
                        r_addr  <= r_mar[ADDR_W-1:0];
                        r_oob   <= w_oob;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_re    <= 1'b0;
                    end
                end

                S_RD_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        // Capture happens only here, where mdr_in is locked
                        // out, so read data always wins over a bus load.
                        r_mdr   <= r_oob ? OOB_PATTERN : ram_rdata;
                        r_re    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                S_WR_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_WR_PULSE;
                        r_we    <= ~r_oob;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                S_WR_PULSE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_re    <= 1'b0;
                end
            endcase
        end
    end

    assign bus_out   = mdr_out ? r_mdr : '0;
    assign mar_q     = r_mar;
    assign mem_busy  = r_busy;
    assign mem_done  = r_done;
    assign mem_err   = r_err;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_mdr;
    assign ram_re    = r_re;
    assign ram_we    = r_we;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed bench for mem_access_unit with default parameters. A behavioural
// RAM with one registered read stage sits on the RAM port. Every access
// pushes its expected MDR onto a scoreboard queue; the entry is popped and
// compared against bus_out when mem_done appears.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] bus_in;
    logic              mar_in;
    logic              mdr_in;
    logic              mdr_out;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] bus_out;
    logic [DATA_W-1:0] mar_q;
    logic              mem_busy;
    logic              mem_done;
    logic              mem_err;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_re;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    mem_access_unit #(
        .DATA_W(32), .ADDR_W(9), .MEM_WORDS(512), .RD_LAT(2), .WR_WAIT(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_in    (bus_in),
        .mar_in    (mar_in),
        .mdr_in    (mdr_in),
        .mdr_out   (mdr_out),
        .read      (read),
        .write     (write),
        .bus_out   (bus_out),
        .mar_q     (mar_q),
        .mem_busy  (mem_busy),
        .mem_done  (mem_done),
        .mem_err   (mem_err),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_re    (ram_re),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: data appears the cycle after ram_re is sampled.
    logic [DATA_W-1:0] mem [512];
    logic              bd_we;
    logic [ADDR_W-1:0] bd_addr;
    logic [DATA_W-1:0] bd_data;

    always @(posedge clk) begin
        if (bd_we)
            mem[bd_addr] <= bd_data;
        else if (ram_we)
            mem[ram_addr] <= ram_wdata;
        if (ram_re)
            ram_rdata <= mem[ram_addr];
    end

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        tick();
        bd_we   = 1'b0;
    endtask

    task automatic load_mar(input logic [DATA_W-1:0] v);
        bus_in = v;
        mar_in = 1'b1;
        tick();
        mar_in = 1'b0;
        bus_in = '0;
    endtask

    task automatic load_mdr(input logic [DATA_W-1:0] v);
        bus_in = v;
        mdr_in = 1'b1;
        tick();
        mdr_in = 1'b0;
        bus_in = '0;
    endtask

    // Waits (bounded) for mem_done starting at cycle index c0 after the
    // strobe was sampled; on done the scoreboard head is compared to bus_out.
    task automatic wait_done(input string tag, input int c0, output int done_cyc,
                             output int re_cnt, output int we_cnt, output int we_cyc,
                             output logic [ADDR_W-1:0] we_addr, output logic [DATA_W-1:0] we_data);
        int c;
        logic [DATA_W-1:0] e;
        c = c0;
        re_cnt = 0; we_cnt = 0; we_cyc = -1; we_addr = '0; we_data = '0;
        while (c < 20 && mem_done !== 1'b1) begin
            if (ram_re === 1'b1) re_cnt++;
            if (ram_we === 1'b1) begin
                we_cnt++;
                we_cyc  = c;
                we_addr = ram_addr;
                we_data = ram_wdata;
            end
            tick();
            c++;
        end
        done_cyc = (mem_done === 1'b1) ? c : -1;
        chk({tag, "_done_seen"}, {31'd0, mem_done}, 32'd1);
        if (mem_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk({tag, "_mdr"}, bus_out, e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int dc, rc, wc, wcy, n_act;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;

    initial begin
        reset = 1'b0; bus_in = '0; mar_in = 1'b0; mdr_in = 1'b0; mdr_out = 1'b1;
        read = 1'b0; write = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;

        preload(9'h055, 32'h1234_5678);
        preload(9'h033, 32'h3333_AAAA);
        preload(9'h000, 32'h0000_A0A0);
        tick();

        // Reset state
        chk("rst_busy", {31'd0, mem_busy}, 32'd0);
        chk("rst_done", {31'd0, mem_done}, 32'd0);
        chk("rst_err",  {31'd0, mem_err},  32'd0);
        chk("rst_re",   {31'd0, ram_re},   32'd0);
        chk("rst_we",   {31'd0, ram_we},   32'd0);
        chk("rst_bus",  bus_out, 32'd0);
        chk("rst_mar",  mar_q,   32'd0);
        reset = 1'b1;
        tick();

        // 1: read of 0x55
        load_mar(32'h0000_0055);
        chk("t1_mar_q", mar_q, 32'h0000_0055);
        exp_q.push_back(32'h1234_5678);
        read = 1'b1; tick(); read = 1'b0;
        chk("t1_busy", {31'd0, mem_busy}, 32'd1);
        wait_done("t1", 1, dc, rc, wc, wcy, wa, wd);
        chk("t1_done_cyc", 32'(dc), 32'd3);
        chk("t1_re_cycles", 32'(rc), 32'd2);
        chk("t1_re_after", {31'd0, ram_re}, 32'd0);
        chk("t1_busy_done", {31'd0, mem_busy}, 32'd0);
        mdr_out = 1'b0; #1;
        chk("t1_bus_gated", bus_out, 32'd0);
        mdr_out = 1'b1;
        tick();
        chk("t1_done_pulse", {31'd0, mem_done}, 32'd0);

        // 2: write 0xCAFE_0001 to 0x87, then read it back
        load_mar(32'h0000_0087);
        load_mdr(32'hCAFE_0001);
        exp_q.push_back(32'hCAFE_0001);
        write = 1'b1; tick(); write = 1'b0;
        wait_done("t2w", 1, dc, rc, wc, wcy, wa, wd);
        chk("t2_done_cyc", 32'(dc), 32'd3);
        chk("t2_we_cnt", 32'(wc), 32'd1);
        chk("t2_we_cyc", 32'(wcy), 32'd2);
        chk("t2_we_addr", {23'd0, wa}, 32'h0000_0087);
        chk("t2_we_data", wd, 32'hCAFE_0001);
        chk("t2_re_cnt", 32'(rc), 32'd0);
        tick();
        load_mdr(32'h0);
        exp_q.push_back(32'hCAFE_0001);
        read = 1'b1; tick(); read = 1'b0;
        wait_done("t2r", 1, dc, rc, wc, wcy, wa, wd);
        chk("t2r_done_cyc", 32'(dc), 32'd3);
        chk("t2_err_clean", {31'd0, mem_err}, 32'd0);
        tick();

        // 4: mdr_in during RD_WAIT is ignored and flags an error
        load_mar(32'h0000_0033);
        exp_q.push_back(32'h3333_AAAA);
        read = 1'b1; tick(); read = 1'b0;
        bus_in = 32'hFFFF_FFFF; mdr_in = 1'b1; tick(); mdr_in = 1'b0; bus_in = '0;
        wait_done("t4", 2, dc, rc, wc, wcy, wa, wd);
        chk("t4_done_cyc", 32'(dc), 32'd3);
        chk("t4_err", {31'd0, mem_err}, 32'd1);
        tick();

        // Reset clears the sticky error
        reset = 1'b0; tick(); reset = 1'b1; tick();
        chk("rst2_err", {31'd0, mem_err}, 32'd0);
        chk("rst2_bus", bus_out, 32'd0);

        // 3: simultaneous read and write -> write wins, error raised
        load_mar(32'h0000_0010);
        load_mdr(32'h0BAD_0003);
        exp_q.push_back(32'h0BAD_0003);
        read = 1'b1; write = 1'b1; tick(); read = 1'b0; write = 1'b0;
        wait_done("t3", 1, dc, rc, wc, wcy, wa, wd);
        chk("t3_done_cyc", 32'(dc), 32'd3);
        chk("t3_re_cnt", 32'(rc), 32'd0);
        chk("t3_we_cnt", 32'(wc), 32'd1);
        chk("t3_we_addr", {23'd0, wa}, 32'h0000_0010);
        chk("t3_err", {31'd0, mem_err}, 32'd1);
        tick(); tick();
        chk("t3_err_sticky", {31'd0, mem_err}, 32'd1);

        // 5: asynchronous reset in the middle of RD_WAIT
        load_mar(32'h0000_0055);
        read = 1'b1; tick(); read = 1'b0;
        chk("t5_re_before", {31'd0, ram_re}, 32'd1);
        reset = 1'b0; #1;
        chk("t5_busy", {31'd0, mem_busy}, 32'd0);
        chk("t5_re",   {31'd0, ram_re},   32'd0);
        chk("t5_err",  {31'd0, mem_err},  32'd0);
        chk("t5_bus",  bus_out, 32'd0);
        chk("t5_mar",  mar_q, 32'd0);
        tick();
        reset = 1'b1;
        n_act = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_done !== 1'b0 || ram_re !== 1'b0) n_act++;
            tick();
        end
        chk("t5_no_done", 32'(n_act), 32'd0);
        chk("t5_mdr_zero", bus_out, 32'd0);
        load_mar(32'h0000_0055);
        exp_q.push_back(32'h1234_5678);
        read = 1'b1; tick(); read = 1'b0;
        wait_done("t5r", 1, dc, rc, wc, wcy, wa, wd);
        chk("t5r_done_cyc", 32'(dc), 32'd3);
        tick();

        // Read held high through DONE does not retrigger
        load_mar(32'h0000_0033);
        exp_q.push_back(32'h3333_AAAA);
        read = 1'b1; tick();
        wait_done("hold", 1, dc, rc, wc, wcy, wa, wd);
        chk("hold_done_cyc", 32'(dc), 32'd3);
        n_act = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_busy !== 1'b0 || mem_done !== 1'b0 || ram_re !== 1'b0) n_act++;
        end
        chk("hold_no_retrigger", 32'(n_act), 32'd0);
        read = 1'b0;
        tick();
        chk("hold_err", {31'd0, mem_err}, 32'd0);

        // 6: MAR beyond the implemented RAM
        load_mar(32'h0000_0200);
`ifdef MEM_BOUNDS_CHECK_EN
        exp_q.push_back(32'hDEAD_BEEF);
`else
        exp_q.push_back(32'h0000_A0A0);
`endif
        read = 1'b1; tick(); read = 1'b0;
        wait_done("t6", 1, dc, rc, wc, wcy, wa, wd);
        chk("t6_done_cyc", 32'(dc), 32'd3);
`ifdef MEM_BOUNDS_CHECK_EN
        chk("t6_re_cnt", 32'(rc), 32'd0);
        chk("t6_err", {31'd0, mem_err}, 32'd1);
`else
        chk("t6_re_cnt", 32'(rc), 32'd2);
        chk("t6_err", {31'd0, mem_err}, 32'd0);
`endif
        tick();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
